// File: rtl/smart_home_pkg.sv
// rtl/smart_home_pkg.sv - shared types, sizes and fan thresholds for the smart_home controller
package smart_home_pkg;

    localparam int NUM_ZONES     = 8;
    localparam int NUM_DOORS     = 3;
    localparam int CLIMATE_ZONES = 3;

    typedef logic [16:0] pw_t;
    typedef logic [6:0]  temp_t;
    typedef logic [2:0]  lux_t;

    localparam temp_t FAN_T1 = 7'd24;
    localparam temp_t FAN_T2 = 7'd29;
    localparam temp_t FAN_T3 = 7'd34;

    function automatic logic [1:0] fan_level(input temp_t t);
        if (t <= FAN_T1) begin
            return 2'd0;
        end else if (t <= FAN_T2) begin
            return 2'd1;
        end else if (t <= FAN_T3) begin
            return 2'd2;
        end
        return 2'd3;
    endfunction

endpackage

// File: rtl/smart_home_if.sv
// rtl/smart_home_if.sv - sensor/button inputs and actuator/alarm outputs of the smart_home controller
interface smart_home_if;
    import smart_home_pkg::*;

    logic [NUM_ZONES-1:0]      smokeDetector;
    logic [NUM_ZONES-1:0]      doorState;
    logic [NUM_ZONES-1:0]      windowState;
    logic [NUM_ZONES-1:0]      humanDetector;
    logic [NUM_ZONES-1:0]      motionSensor;
    logic [NUM_ZONES-1:0]      lock_button;
    logic [NUM_DOORS-1:0]      doorEnable;
    logic [NUM_DOORS-1:0]      rs_buttonState;
    logic [NUM_DOORS-1:0]      e_buttonState;
    pw_t  [NUM_DOORS-1:0]      in_password;
    pw_t  [NUM_DOORS-1:0]      change_password;
    temp_t [CLIMATE_ZONES-1:0] temperature;
    lux_t  [CLIMATE_ZONES-1:0] luminosity;
    logic                      stove_state;
    logic                      garageState;
    pw_t                       garage_in_password;
    pw_t                       garage_change_password;
    logic                      garage_rs_button;
    logic                      garage_e_button;
    logic                      garage_lock_button;

    logic [NUM_ZONES-1:0]      burglar_alarm_enable;
    logic                      unlock;
    logic                      fire_alarm;
    logic                      chimney;
    logic                      garage_alarm;
    logic                      garageLocked;
    logic [NUM_ZONES-1:0]      light;
    logic [NUM_ZONES-1:0]      heater;
    logic [NUM_ZONES-1:0]      airConditioner;
    logic [NUM_ZONES-1:0][1:0] fan_speed;

    modport master (
        output smokeDetector, doorState, windowState, humanDetector, motionSensor,
               lock_button, doorEnable, rs_buttonState, e_buttonState, in_password,
               change_password, temperature, luminosity, stove_state, garageState,
               garage_in_password, garage_change_password, garage_rs_button,
               garage_e_button, garage_lock_button,
        input  burglar_alarm_enable, unlock, fire_alarm, chimney, garage_alarm,
               garageLocked, light, heater, airConditioner, fan_speed
    );

    modport slave (
        input  smokeDetector, doorState, windowState, humanDetector, motionSensor,
               lock_button, doorEnable, rs_buttonState, e_buttonState, in_password,
               change_password, temperature, luminosity, stove_state, garageState,
               garage_in_password, garage_change_password, garage_rs_button,
               garage_e_button, garage_lock_button,
        output burglar_alarm_enable, unlock, fire_alarm, chimney, garage_alarm,
               garageLocked, light, heater, airConditioner, fan_speed
    );

endinterface

// File: rtl/smart_home_pw_lock.sv
// rtl/smart_home_pw_lock.sv - password lock: stored password, button edge detect, locked flag, change logic
module pw_lock
    import smart_home_pkg::*;
#(
    parameter pw_t DEFAULT_PW = 17'd45675
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  pw_t  in_password,
    input  pw_t  change_password,
    input  logic rs_button,
    input  logic e_button,
    input  logic lock_button,
    output logic locked,
    output logic unlock_event
);

    pw_t  stored;
    logic e_q;
    logic lock_q;
    logic e_rise;
    logic lock_rise;
    logic match;

    always_comb begin
        e_rise       = e_button & ~e_q;
        lock_rise    = lock_button & ~lock_q;
        match        = (in_password == stored);
        unlock_event = e_rise & ~rs_button & enable & match;
    end

    // Edge registers load the live button during reset so a held button never looks like a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            stored <= DEFAULT_PW;
            locked <= 1'b1;
            e_q    <= e_button;
            lock_q <= lock_button;
        end else begin
            e_q    <= e_button;
            lock_q <= lock_button;
            if (e_rise && rs_button && match) begin
                stored <= change_password;
            end
            if (lock_rise) begin
                locked <= 1'b1;
            end else if (unlock_event) begin
                locked <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/smart_home_ctrl.sv
// rtl/smart_home_ctrl.sv - whole-house controller top; SMART_HOME_GARAGE_EN builds the garage password lock
module smart_home_ctrl
    import smart_home_pkg::*;
#(
    parameter pw_t   DEFAULT_PW = 17'd45675,
    parameter temp_t HEAT_BELOW = 7'd18,
    parameter temp_t COOL_ABOVE = 7'd26,
    parameter lux_t  DARK_BELOW = 3'd3
) (
    input  logic        clk,
    input  logic        rst,
    smart_home_if.slave io
);

    logic [NUM_DOORS-1:0]      door_locked;
    logic [NUM_DOORS-1:0]      door_unlock_evt;
    logic [NUM_ZONES-1:0]      lock_q;
    logic [NUM_ZONES-1:0]      lock_rise;
    logic [NUM_ZONES-1:0]      armed;
    logic [NUM_ZONES-1:0]      light_d;
    logic [NUM_ZONES-1:0]      heater_d;
    logic [NUM_ZONES-1:0]      cool_d;
    logic [NUM_ZONES-1:0][1:0] fan_d;
    logic                      garage_locked;
    logic                      garage_alarm_d;

    generate
        for (genvar d = 0; d < NUM_DOORS; d++) begin : g_door
            pw_lock #(.DEFAULT_PW(DEFAULT_PW)) u_lock (
                .clk             (clk),
                .rst             (rst),
                .enable          (io.doorEnable[d]),
                .in_password     (io.in_password[d]),
                .change_password (io.change_password[d]),
                .rs_button       (io.rs_buttonState[d]),
                .e_button        (io.e_buttonState[d]),
                .lock_button     (io.lock_button[d]),
                .locked          (door_locked[d]),
                .unlock_event    (door_unlock_evt[d])
            );
        end
    endgenerate

`ifdef SMART_HOME_GARAGE_EN
    logic garage_unlock_evt;

    pw_lock #(.DEFAULT_PW(DEFAULT_PW)) u_garage_lock (
        .clk             (clk),
        .rst             (rst),
        .enable          (1'b1),
        .in_password     (io.garage_in_password),
        .change_password (io.garage_change_password),
        .rs_button       (io.garage_rs_button),
        .e_button        (io.garage_e_button),
        .lock_button     (io.garage_lock_button),
        .locked          (garage_locked),
        .unlock_event    (garage_unlock_evt)
    );

    assign garage_alarm_d = garage_locked & io.garageState;
`else
    // Without a garage lock the garage counts as permanently locked, so any opening alarms.
    assign garage_locked  = 1'b1;
    assign garage_alarm_d = io.garageState;
`endif

    assign io.garageLocked = garage_locked;
    assign lock_rise       = io.lock_button & ~lock_q;

    always_comb begin
        light_d  = io.motionSensor;
        heater_d = '0;
        cool_d   = '0;
        fan_d    = '0;
        for (int i = 0; i < CLIMATE_ZONES; i++) begin
            light_d[i] = io.motionSensor[i] & (io.luminosity[i] < DARK_BELOW);
            if (io.humanDetector[i]) begin
                heater_d[i] = (io.temperature[i] < HEAT_BELOW);
                cool_d[i]   = (io.temperature[i] > COOL_ABOVE);
                fan_d[i]    = fan_level(io.temperature[i]);
            end
        end
    end

    // A fresh arm press wins over a simultaneous disarm by unlock.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q                  <= io.lock_button;
            armed                   <= '0;
            io.burglar_alarm_enable <= '0;
            io.unlock               <= 1'b0;
            io.fire_alarm           <= 1'b0;
            io.chimney              <= 1'b0;
            io.garage_alarm         <= 1'b0;
            io.light                <= '0;
            io.heater               <= '0;
            io.airConditioner       <= '0;
            io.fan_speed            <= '0;
        end else begin
            lock_q                  <= io.lock_button;
            armed                   <= (armed & ~{NUM_ZONES{|door_unlock_evt}}) | lock_rise;
            io.burglar_alarm_enable <= armed & (io.doorState | io.windowState | io.humanDetector);
            io.unlock               <= |(~door_locked);
            io.fire_alarm           <= |io.smokeDetector;
            io.chimney              <= io.stove_state | (|io.smokeDetector);
            io.garage_alarm         <= garage_alarm_d;
            io.light                <= light_d;
            io.heater               <= heater_d;
            io.airConditioner       <= cool_d;
            io.fan_speed            <= fan_d;
        end
    end

endmodule

// File: tb/tb_smart_home_ctrl.sv
// tb/tb_smart_home_ctrl.sv - self-checking bench for smart_home_ctrl: vector table plus lock/arming/garage sequences
module tb_smart_home_ctrl;
    import smart_home_pkg::*;

`ifdef SMART_HOME_GARAGE_EN
    localparam bit GARAGE_EN = 1'b1;
`else
    localparam bit GARAGE_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    smart_home_if io();

    smart_home_ctrl dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] hd;
        logic [7:0] mo;
        logic [6:0] t;
        logic [2:0] lux;
        logic [7:0] smoke;
        logic       stove;
        logic       gs;
        logic [7:0] heat;
        logic [7:0] ac;
        logic [15:0] fan;
        logic [7:0] lt;
        logic       fire;
        logic       chim;
        logic       galarm;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [1:0] exp_fan(input int t);
        if (t >= 35) return 2'd3;
        if (t >= 30) return 2'd2;
        if (t >= 25) return 2'd1;
        return 2'd0;
    endfunction

    function automatic vec_t mk(input logic [7:0] hd, input logic [7:0] mo, input int t,
                                input int lux, input logic [7:0] smoke, input logic stove,
                                input logic gs);
        vec_t v;
        v.hd = hd; v.mo = mo; v.t = 7'(t); v.lux = 3'(lux);
        v.smoke = smoke; v.stove = stove; v.gs = gs;
        // zones 1-2 sit at 20 C and full brightness: no climate action, no light
        v.heat  = {7'b0, hd[0] & (t < 18)};
        v.ac    = {7'b0, hd[0] & (t > 26)};
        v.fan   = {14'b0, hd[0] ? exp_fan(t) : 2'd0};
        v.lt    = {mo[7:3], 2'b00, mo[0] & (lux < 3)};
        v.fire  = (smoke != 8'h00);
        v.chim  = stove | (smoke != 8'h00);
        v.galarm = gs;
        return v;
    endfunction

    task automatic idle();
        io.smokeDetector = '0; io.doorState = '0; io.windowState = '0;
        io.humanDetector = '0; io.motionSensor = '0; io.lock_button = '0;
        io.doorEnable = '0; io.rs_buttonState = '0; io.e_buttonState = '0;
        io.in_password = '0; io.change_password = '0;
        io.temperature[0] = 7'd20; io.temperature[1] = 7'd20; io.temperature[2] = 7'd20;
        io.luminosity[0] = 3'd7; io.luminosity[1] = 3'd7; io.luminosity[2] = 3'd7;
        io.stove_state = 1'b0; io.garageState = 1'b0;
        io.garage_in_password = '0; io.garage_change_password = '0;
        io.garage_rs_button = 1'b0; io.garage_e_button = 1'b0; io.garage_lock_button = 1'b0;
    endtask

    task automatic door_try(input int d, input logic rs, input pw_t pw, input pw_t chg);
        io.rs_buttonState[d] = rs;
        io.in_password[d] = pw;
        io.change_password[d] = chg;
        io.e_buttonState[d] = 1'b1;
        tick(1);
        io.e_buttonState[d] = 1'b0;
        tick(1);
    endtask

    task automatic garage_try(input logic rs, input pw_t pw, input pw_t chg);
        io.garage_rs_button = rs;
        io.garage_in_password = pw;
        io.garage_change_password = chg;
        io.garage_e_button = 1'b1;
        tick(1);
        io.garage_e_button = 1'b0;
        tick(1);
    endtask

    task automatic lock_pulse(input logic [7:0] m);
        io.lock_button = m;
        tick(1);
        io.lock_button = '0;
        tick(1);
    endtask

    initial begin
        vec_t e;
        for (int t = 0; t < 128; t++) vecs.push_back(mk(8'h01, 8'h00, t, 7, 8'h00, 1'b0, 1'b0));
        for (int t = 0; t < 128; t += 31) vecs.push_back(mk(8'h00, 8'h00, t, 7, 8'h00, 1'b0, 1'b0));
        vecs.push_back(mk(8'hFE, 8'h00, 10, 7, 8'h00, 1'b0, 1'b0));
        for (int l = 0; l < 8; l++) vecs.push_back(mk(8'h00, 8'h01, 20, l, 8'h00, 1'b0, 1'b0));
        vecs.push_back(mk(8'h00, 8'h00, 20, 0, 8'h00, 1'b0, 1'b0));
        vecs.push_back(mk(8'h00, 8'hF8, 20, 0, 8'h00, 1'b0, 1'b0));
        vecs.push_back(mk(8'h00, 8'h00, 20, 7, 8'h01, 1'b0, 1'b0));
        vecs.push_back(mk(8'h00, 8'h00, 20, 7, 8'h00, 1'b1, 1'b0));
        vecs.push_back(mk(8'h00, 8'h00, 20, 7, 8'h80, 1'b1, 1'b0));
        vecs.push_back(mk(8'h00, 8'h00, 20, 7, 8'h00, 1'b0, 1'b1));

        // reset with a lock button held: it must not arm zone 3
        idle();
        rst = 1'b1;
        io.lock_button = 8'h08;
        tick(3);
        rst = 1'b0;
        tick(2);
        chk("rst_unlock", 32'(io.unlock), 32'd0);
        chk("rst_burglar", 32'(io.burglar_alarm_enable), 32'd0);
        chk("rst_fire", 32'(io.fire_alarm), 32'd0);
        chk("rst_chimney", 32'(io.chimney), 32'd0);
        chk("rst_light", 32'(io.light), 32'd0);
        chk("rst_heater", 32'(io.heater), 32'd0);
        chk("rst_ac", 32'(io.airConditioner), 32'd0);
        chk("rst_fan", 32'(io.fan_speed), 32'd0);
        chk("rst_garage_locked", 32'(io.garageLocked), 32'd1);
        chk("rst_garage_alarm", 32'(io.garage_alarm), 32'd0);
        io.doorState = 8'h08;
        tick(1);
        chk("held_button_no_arm", 32'(io.burglar_alarm_enable), 32'd0);
        io.doorState = '0;
        io.lock_button = '0;
        tick(1);

        foreach (vecs[k]) begin
            io.humanDetector = vecs[k].hd;
            io.motionSensor = vecs[k].mo;
            io.temperature[0] = vecs[k].t;
            io.luminosity[0] = vecs[k].lux;
            io.smokeDetector = vecs[k].smoke;
            io.stove_state = vecs[k].stove;
            io.garageState = vecs[k].gs;
            sb.push_back(vecs[k]);
            tick(1);
            e = sb.pop_front();
            chk($sformatf("heater[%0d]", k), 32'(io.heater), 32'(e.heat));
            chk($sformatf("ac[%0d]", k), 32'(io.airConditioner), 32'(e.ac));
            chk($sformatf("fan[%0d]", k), 32'(io.fan_speed), 32'(e.fan));
            chk($sformatf("light[%0d]", k), 32'(io.light), 32'(e.lt));
            chk($sformatf("fire[%0d]", k), 32'(io.fire_alarm), 32'(e.fire));
            chk($sformatf("chimney[%0d]", k), 32'(io.chimney), 32'(e.chim));
            chk($sformatf("garage_alarm[%0d]", k), 32'(io.garage_alarm), 32'(e.galarm));
        end
        idle();
        tick(1);

        door_try(1, 1'b1, 17'd45675, 17'd78954);
        chk("change_keeps_locked", 32'(io.unlock), 32'd0);
        io.doorEnable = 3'b010;
        door_try(1, 1'b0, 17'd45675, 17'd0);
        chk("old_pw_rejected", 32'(io.unlock), 32'd0);
        door_try(1, 1'b0, 17'd78954, 17'd0);
        chk("new_pw_unlocks", 32'(io.unlock), 32'd1);
        for (int r = 0; r < 3; r++) begin
            door_try(1, 1'b0, 17'd45, 17'd0);
            chk($sformatf("wrong_pw_%0d", r), 32'(io.unlock), 32'd1);
        end
        lock_pulse(8'h02);
        chk("relock_door1", 32'(io.unlock), 32'd0);

        lock_pulse(8'h20);
        io.doorState = 8'h20;
        tick(1);
        chk("burglar_door5", 32'(io.burglar_alarm_enable), 32'h20);
        io.windowState = 8'h02;
        tick(1);
        chk("burglar_window1", 32'(io.burglar_alarm_enable), 32'h22);
        io.windowState = '0;
        door_try(1, 1'b0, 17'd78954, 17'd0);
        chk("unlock_disarms", 32'(io.burglar_alarm_enable), 32'h00);
        chk("unlock_again", 32'(io.unlock), 32'd1);
        lock_pulse(8'h02);
        io.doorState = '0;

        io.doorEnable = 3'b000;
        door_try(0, 1'b0, 17'd45675, 17'd0);
        chk("enable_blocks", 32'(io.unlock), 32'd0);
        io.doorEnable = 3'b001;
        door_try(0, 1'b0, 17'd45675, 17'd0);
        chk("door0_unlock", 32'(io.unlock), 32'd1);
        lock_pulse(8'h01);
        chk("door0_relock", 32'(io.unlock), 32'd0);
        io.lock_button = 8'h01;
        io.in_password[0] = 17'd45675;
        io.rs_buttonState[0] = 1'b0;
        io.e_buttonState[0] = 1'b1;
        tick(1);
        io.lock_button = '0;
        io.e_buttonState[0] = 1'b0;
        tick(1);
        chk("lock_beats_unlock", 32'(io.unlock), 32'd0);

        io.garageState = 1'b1;
        tick(1);
        chk("garage_open_alarm", 32'(io.garage_alarm), 32'd1);
        chk("garage_locked_init", 32'(io.garageLocked), 32'd1);
        garage_try(1'b0, 17'd45675, 17'd0);
        chk("garage_pw_locked", 32'(io.garageLocked), GARAGE_EN ? 32'd0 : 32'd1);
        chk("garage_pw_alarm", 32'(io.garage_alarm), GARAGE_EN ? 32'd0 : 32'd1);
        io.garage_lock_button = 1'b1;
        tick(1);
        io.garage_lock_button = 1'b0;
        tick(1);
        chk("garage_relock", 32'(io.garageLocked), 32'd1);
        chk("garage_relock_alarm", 32'(io.garage_alarm), 32'd1);
        garage_try(1'b1, 17'd45675, 17'd222);
        garage_try(1'b0, 17'd45675, 17'd0);
        chk("garage_old_pw", 32'(io.garageLocked), 32'd1);
        garage_try(1'b0, 17'd222, 17'd0);
        chk("garage_new_pw", 32'(io.garageLocked), GARAGE_EN ? 32'd0 : 32'd1);
        io.garageState = 1'b0;

        door_try(2, 1'b1, 17'd45675, 17'd11111);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        chk("midrst_unlock", 32'(io.unlock), 32'd0);
        chk("midrst_garage_locked", 32'(io.garageLocked), 32'd1);
        io.doorEnable = 3'b100;
        door_try(2, 1'b0, 17'd45675, 17'd0);
        chk("midrst_default_pw", 32'(io.unlock), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
